// File: rtl/bin_cnt_seq.sv
// bin_cnt_seq: 4-bit count controller for the structural binary counter.
// Owns the count register and the IDLE/RUN/DONE control FSM. The block never
// adds on its own; every increment is taken from the external incrementer
// (inc_a -> inc_sum). It adds start/stop, a prescaled tick, synchronous load,
// free-run or one-shot modes and a registered terminal-count pulse.
module bin_cnt_seq #(
    parameter int PRESCALE = 1  // enabled RUN cycles per count tick, 1..16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       en,
    input  logic       oneshot,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic [3:0] inc_sum,
    output logic [3:0] inc_a,
    output logic [3:0] cnt,
    output logic       tc,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last prescaler phase before a tick; 4 bits cover PRESCALE up to 16.
    localparam logic [3:0] PS_MAX = 4'(PRESCALE - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] presc_q, presc_d;
    logic       mode_q, mode_d;
    logic       tc_q, tc_d;

    // State register: every piece of control state updates on the same edge.
    // NOTE: non-blocking assignments here so all registers sample the
    // pre-edge values computed by the combinational block below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            presc_q <= 4'd0;
            mode_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            mode_q  <= mode_d;
            tc_q    <= tc_d;
        end
    end

    // Next-state logic, priority load > stop > start > tick.
    always_comb begin
        // NOTE: every output gets a hold/default value first so that no path
        // through the if-chain leaves a variable unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        mode_d  = mode_q;
        tc_d    = 1'b0;

        if (load) begin
            // Load overrides everything; DONE is left so the new value can
            // be counted from after the next start.
            cnt_d   = load_val;
            presc_d = 4'd0;
            if (state_q == DONE) begin
                state_d = IDLE;
            end
        end else if (stop) begin
            // Stop also masks a simultaneous start, even where it is ignored.
            if (state_q == RUN) begin
                state_d = IDLE;
                presc_d = 4'd0;
            end
        end else if (start && (state_q != RUN)) begin
            state_d = RUN;
            presc_d = 4'd0;
            mode_d  = oneshot;
            if (state_q == DONE) begin
                cnt_d = 4'd0;
            end
        end else if ((state_q == RUN) && en) begin
            if (presc_q == PS_MAX) begin
                presc_d = 4'd0;
                if (mode_q && (cnt_q == 4'hF)) begin
                    // One-shot terminal tick: park at 15, incrementer ignored.
                    state_d = DONE;
                    tc_d    = 1'b1;
                end else begin
                    cnt_d = inc_sum;
                    tc_d  = (cnt_q == 4'hF);
                end
            end else begin
                presc_d = presc_q + 4'd1;
            end
        end
    end

    assign inc_a = cnt_q;
    assign cnt   = cnt_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule
